// File: rtl/ber_pkg.sv
// ber_pkg: checker state encodings and PRBS7 (x^7+x^6+1) register geometry.
package ber_pkg;
   localparam logic [1:0] ST_SEED   = 2'd0;
   localparam logic [1:0] ST_HUNT   = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;
   localparam int PRBS_LEN   = 7;
   localparam int PRBS_TAP_A = 6;
   localparam int PRBS_TAP_B = 5;
   typedef enum logic [1:0] {
      SEED   = ST_SEED,
      HUNT   = ST_HUNT,
      LOCKED = ST_LOCKED
   } state_t;
endpackage

// File: rtl/prbs7_lfsr.sv
// prbs7_lfsr: PRBS7 register that either loads serial data or free-runs on its own prediction.
module prbs7_lfsr
   import ber_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic load_i,
   input  logic shift_i,
   input  logic sin_i,
   output logic pred_o
);
   logic [PRBS_LEN-1:0] lfsr_q, lfsr_d;
   assign pred_o = lfsr_q[PRBS_TAP_A] ^ lfsr_q[PRBS_TAP_B];
   always_comb lfsr_d = clr_i   ? '0 :
                        load_i  ? {lfsr_q[PRBS_LEN-2:0], sin_i} :
                        shift_i ? {lfsr_q[PRBS_LEN-2:0], pred_o} : lfsr_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) lfsr_q <= '0;
      else        lfsr_q <= lfsr_d;
endmodule

// File: rtl/ber_meter.sv
// ber_meter: PRBS7 sync checker that reports per-window bit error counts once locked.
module ber_meter
   import ber_pkg::*;
#(
   parameter int WIN     = 20,
   parameter int EBW     = 16,
   parameter int LOCK_N  = 32,
   parameter int LOSS_TH = 64
) (
   input  logic           CLK,
   input  logic           RSTX,
   input  logic           CLR,
   input  logic           DIN,
   input  logic           DIN_VLD,
   output logic           LOCK,
   output logic [EBW-1:0] ERR_CNT,
   output logic           DONE
);
   // one counter serves as seed-bit count in SEED and match count in HUNT
   localparam int CW = ($clog2(LOCK_N) > 3) ? $clog2(LOCK_N) : 3;
   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [WIN-1:0] bit_q, bit_d;
   logic [EBW-1:0] err_q, err_d, err_cnt_q, err_cnt_d, err_inc;
   logic           done_q, done_d, lock_q;
   logic           pred, miss, loss;
   prbs7_lfsr u_lfsr (
      .clk    (CLK),
      .rst_n  (RSTX),
      .clr_i  (CLR),
      .load_i (!CLR && DIN_VLD && state_q == SEED),
      .shift_i(!CLR && DIN_VLD && state_q != SEED),
      .sin_i  (DIN),
      .pred_o (pred)
   );
   assign miss    = DIN ^ pred;
   assign err_inc = (miss && !(&err_q)) ? err_q + 1'b1 : err_q;
   assign loss    = miss && (err_inc == EBW'(LOSS_TH));
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;
      done_d    = 1'b0;
      if (CLR) begin
         state_d   = SEED;
         cnt_d     = '0;
         bit_d     = '0;
         err_d     = '0;
         err_cnt_d = '0;
      end else if (DIN_VLD) begin
         if (state_q == SEED) begin
            state_d = (cnt_q == CW'(PRBS_LEN-1)) ? HUNT : SEED;
            cnt_d   = (cnt_q == CW'(PRBS_LEN-1)) ? '0 : cnt_q + 1'b1;
         end else if (state_q == HUNT) begin
            if (miss) begin
               state_d = SEED;
               cnt_d   = '0;
            end else if (cnt_q == CW'(LOCK_N-1)) begin
               state_d = LOCKED;
               cnt_d   = '0;
               bit_d   = '0;
               err_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
         end else begin
            bit_d = bit_q + 1'b1;
            err_d = err_inc;
            // loss of lock takes priority over a coincident window end
            if (loss) begin
               state_d = SEED;
               cnt_d   = '0;
               bit_d   = '0;
               err_d   = '0;
            end else if (&bit_q) begin
               err_cnt_d = err_inc;
               done_d    = 1'b1;
               err_d     = '0;
            end
         end
      end
   end
   always_ff @(posedge CLK or negedge RSTX)
      if (!RSTX) begin
         state_q   <= SEED;
         cnt_q     <= '0;
         bit_q     <= '0;
         err_q     <= '0;
         err_cnt_q <= '0;
         done_q    <= 1'b0;
         lock_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         done_q    <= done_d;
         lock_q    <= (state_d == LOCKED);
      end
   assign LOCK    = lock_q;
   assign ERR_CNT = err_cnt_q;
   assign DONE    = done_q;
endmodule

// File: tb/tb_ber_meter.sv
// tb_ber_meter: PRBS7 stimulus and corner sequences checked against a queue-based reference.
module tb_ber_meter;
   localparam int WIN = 8, EBW = 16, LOCK_N = 32, LOSS_TH = 64, WLEN = 1 << WIN;
   logic           CLK = 0, RSTX = 1, CLR = 0, DIN = 0, DIN_VLD = 0;
   logic           LOCK, DONE;
   logic [EBW-1:0] ERR_CNT;
   int  total = 0, bad = 0;
   int  n_done = 0, last_err = 0;
   int  m_st, m_n, m_bits, m_errs, m_err;
   bit  m_done, m_lock;
   bit  hist[$];
   logic [6:0] g = 7'h5a;
   typedef struct {
      logic clr, vld, din, e_lock, e_done;
      logic [EBW-1:0] e_err;
   } vec_t;
   vec_t tbl[6];
   ber_meter #(.WIN(WIN), .EBW(EBW), .LOCK_N(LOCK_N), .LOSS_TH(LOSS_TH)) dut (
      .CLK(CLK), .RSTX(RSTX), .CLR(CLR), .DIN(DIN), .DIN_VLD(DIN_VLD),
      .LOCK(LOCK), .ERR_CNT(ERR_CNT), .DONE(DONE)
   );
   always #5 CLK = ~CLK;
   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_st = 0; m_n = 0; m_bits = 0; m_errs = 0; m_err = 0; m_done = 0; m_lock = 0;
      hist.delete();
   endtask
   // reference: states 0=seed 1=hunt 2=locked; hist holds the last 7 reference bits
   task automatic model_step(input logic d, input logic v, input logic c);
      bit e;
      m_done = 0;
      if (c) model_reset();
      else if (v) begin
         if (m_st == 0) begin
            hist.push_back(d);
            m_n++;
            if (m_n == 7) begin m_st = 1; m_n = 0; end
         end else begin
            e = hist[hist.size()-7] ^ hist[hist.size()-6];
            hist.push_back(e);
            if (m_st == 1) begin
               if (d != e) begin m_st = 0; m_n = 0; end
               else begin
                  m_n++;
                  if (m_n == LOCK_N) begin m_st = 2; m_bits = 0; m_errs = 0; end
               end
            end else begin
               m_bits++;
               if (d != e && m_errs < (1 << EBW) - 1) m_errs++;
               if (d != e && m_errs == LOSS_TH) begin
                  m_st = 0; m_n = 0; m_bits = 0; m_errs = 0;
               end else if (m_bits == WLEN) begin
                  m_err = m_errs; m_done = 1; m_errs = 0; m_bits = 0;
               end
            end
         end
         while (hist.size() > 7) void'(hist.pop_front());
      end
      m_lock = (m_st == 2);
   endtask
   task automatic cyc(input logic d, input logic v, input logic c);
      DIN = d; DIN_VLD = v; CLR = c;
      @(posedge CLK);
      model_step(d, v, c);
      #1;
      check("lock", int'(LOCK), int'(m_lock));
      check("done", int'(DONE), int'(m_done));
      check("err_cnt", int'(ERR_CNT), m_err);
      if (DONE) begin n_done++; last_err = int'(ERR_CNT); end
   endtask
   task automatic gen(output logic b);
      b = g[6] ^ g[5];
      g = {g[5:0], b};
   endtask
   task automatic send(input int n, input bit gap, input bit inv = 0,
                       input int fa = -1, input int fb = -1, input int fc = -1);
      logic b;
      for (int i = 0; i < n; i++) begin
         if (gap) cyc(1'($urandom_range(1)), 1'b0, 1'b0);
         gen(b);
         cyc(b ^ (inv || i == fa || i == fb || i == fc), 1'b1, 1'b0);
      end
   endtask
   task automatic relock(input string nm, input bit gap);
      int n = 0;
      for (int k = 0; k < 300 && !LOCK; k++) begin
         send(1, gap);
         n++;
      end
      check({nm, "_lock_bits"}, n, 39);
      check({nm, "_locked"}, int'(LOCK), 1);
   endtask
   task automatic hard_reset();
      RSTX = 0;
      #1;
      check("rst_lock", int'(LOCK), 0);
      check("rst_done", int'(DONE), 0);
      check("rst_err", int'(ERR_CNT), 0);
      model_reset();
      @(posedge CLK);
      @(posedge CLK);
      #1 RSTX = 1;
   endtask
   initial begin
      int d0, seen;
      logic b;
      tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0};
      #2;
      hard_reset();
      for (int i = 0; i < 6; i++) begin
         cyc(tbl[i].din, tbl[i].vld, tbl[i].clr);
         check("tbl_lock", int'(LOCK), int'(tbl[i].e_lock));
         check("tbl_done", int'(DONE), int'(tbl[i].e_done));
         check("tbl_err", int'(ERR_CNT), int'(tbl[i].e_err));
      end
      // clean stream: lock after 39 bits, one DONE per 256 bits with zero errors
      relock("clean", 0);
      d0 = n_done;
      send(3 * WLEN, 0);
      check("clean_dones", n_done - d0, 3);
      check("clean_err", last_err, 0);
      send(WLEN, 0, 0, 10, 100, 200);
      check("flip_dones", n_done - d0, 4);
      check("flip_err", last_err, 3);
      send(WLEN, 0);
      check("after_flip_err", last_err, 0);
      // sustained inversion drops lock on the 64th error
      send(LOSS_TH - 1, 0, 1);
      check("loss_pre", int'(LOCK), 1);
      send(1, 0, 1);
      check("loss_at_64", int'(LOCK), 0);
      check("loss_err_held", int'(ERR_CNT), 0);
      send(80 - LOSS_TH, 0, 1);
      relock("after_loss", 0);
      send(WLEN, 0, 0, 5, 50);
      check("pre_clr_err", last_err, 2);
      send(100, 0);
      d0 = n_done;
      for (int i = 0; i < 3; i++) begin
         gen(b);
         cyc(b, 1'b1, 1'b1);
         check("clr_lock", int'(LOCK), 0);
         check("clr_err", int'(ERR_CNT), 0);
         check("clr_done", int'(DONE), 0);
      end
      check("clr_no_done", n_done - d0, 0);
      relock("after_clr", 0);
      // gapped valid: same lock distance and window results as continuous
      hard_reset();
      relock("gap", 1);
      d0 = n_done;
      send(WLEN, 1);
      check("gap_err0", last_err, 0);
      send(WLEN, 1, 0, 3, 128, 255);
      check("gap_err3", last_err, 3);
      check("gap_dones", n_done - d0, 2);
      // random data must never lock
      cyc(1'b0, 1'b0, 1'b1);
      d0 = n_done;
      seen = 0;
      for (int i = 0; i < 10000; i++) begin
         cyc(1'($urandom_range(1)), 1'b1, 1'b0);
         if (LOCK) seen++;
      end
      check("rand_lock_seen", seen, 0);
      check("rand_dones", n_done - d0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ber_meter.md
BER_METER -- requirements
Module: ber_meter

Interface
REQ-001 Parameter WIN, default 20: log2 of measurement window length in valid bits.
REQ-002 Parameter EBW, default 16: error-count width.
REQ-003 Parameter LOCK_N, default 32: consecutive matches required to declare lock.
REQ-004 Parameter LOSS_TH, default 64: errors within one window that force loss of lock.
REQ-005 Port CLK  input  1: single clock for the whole block.
REQ-006 Port RSTX  input  1: reset, asynchronous and active-low.
REQ-007 Port CLR  input  1: synchronous clear request, driven from the CLR_SEQ output of the button-control stage.
REQ-008 Port DIN  input  1: received serial bit.
REQ-009 Port DIN_VLD  input  1: DIN is valid this cycle; the block ignores DIN when low.
REQ-010 Port LOCK  output  1: high while the checker is synchronised to the incoming PRBS7.
REQ-011 Port ERR_CNT  output  EBW: error count of the last completed window.
REQ-012 Port DONE  output  1: one-cycle pulse when ERR_CNT is updated.

Function
REQ-013 Reference pattern is PRBS7, polynomial x^7+x^6+1, 7-bit LFSR; predicted bit = lfsr[6] XOR lfsr[5].
REQ-014 State machine states: SEED, HUNT, LOCKED; registered, one transition per clock at most.
REQ-015 SEED: each valid bit shifts DIN into the LFSR; after 7 valid bits go to HUNT with match count 0.
REQ-016 HUNT: each valid bit compares DIN with the predicted bit, and the LFSR shifts in its own predicted bit.
REQ-017 HUNT mismatch: go to SEED, clear match count.
REQ-018 HUNT match: increment match count; on reaching LOCK_N go to LOCKED with window bit counter and window error counter at 0.
REQ-019 LOCKED: the LFSR free-runs on its own feedback per valid bit; DIN never loads it.
REQ-020 LOCKED: each valid bit increments the window bit counter (WIN bits wide).
REQ-021 LOCKED mismatch: increment the window error counter, saturating at all-ones (EBW bits).
REQ-022 Window end: on the valid bit that wraps the window bit counter from 2^WIN-1 to 0, ERR_CNT shall equal the window error count including that bit; DONE shall be high for exactly the next cycle; the window error counter restarts at 0.
REQ-023 Loss of lock: when the window error count reaches LOSS_TH, go to SEED and clear all counters; ERR_CNT is held.
REQ-024 If loss of lock and window end occur on the same bit, loss of lock wins: no DONE, ERR_CNT unchanged.
REQ-025 LOCK is a registered output, high exactly while state == LOCKED.
REQ-026 CLR high: next state SEED; LFSR, match, bit and error counters cleared; ERR_CNT = 0; DONE = 0; LOCK = 0 on the next cycle.
REQ-027 CLR and DIN_VLD in the same cycle: CLR wins and the bit is discarded.
REQ-028 CLR held for multiple cycles: the block stays in SEED and consumes no bits until CLR is low.
REQ-029 Gaps in DIN_VLD shall not alter any result; only the count of valid bits matters.

Reset
REQ-030 RSTX low asynchronously forces: state SEED, LFSR 0, all counters 0, LOCK 0, ERR_CNT 0, DONE 0.
REQ-031 Reset release takes effect on the first CLK edge with RSTX high; no other reset-sequencing requirement applies.

Structure
REQ-032 State encodings and the PRBS7 tap positions shall be localparams in a shared ber_pkg include file.
REQ-033 The LFSR shall be one sub-module, prbs7_lfsr, with ports load-enable, shift-enable, serial-in and predicted-bit-out; it shall be reused by the transmit-side generator.
REQ-034 All other logic shall sit in ber_meter; all outputs shall be flopped.

Verification
REQ-035 Bench shall cover: WIN=8; clean PRBS7 with DIN_VLD=1 after reset -> LOCK rises the cycle after the 39th valid bit; DONE every 256 valid bits; ERR_CNT=0.
REQ-036 Bench shall cover: locked, 3 single-bit flips inside one window -> that window's DONE shows ERR_CNT=3; the following clean window shows 0.
REQ-037 Bench shall cover: 80 consecutive inverted bits while locked -> LOCK falls after the 64th error; clean data then gives relock after 39 more valid bits.
REQ-038 Bench shall cover: CLR pulse mid-window while locked -> next cycle LOCK=0, ERR_CNT=0, no DONE; relock after 39 valid bits.
REQ-039 Bench shall cover: DIN_VLD toggling every other cycle -> identical LOCK timing (counted in valid bits) and identical ERR_CNT values versus the continuous case.
REQ-040 Bench shall cover: random non-PRBS data for 10000 bits -> LOCK never asserts and DONE never pulses.
